dds_lut_reader: RTL and testbench
=================================

Name: dds_lut_reader

Overview:
- Phase-accumulator address generator and sample register sitting in front of the asynchronous sine LUT ROM.
- Acts as the initiator on that interface: drives the LUT address, captures the returned word into a registered sample stream, and flags phase wrap.
- Feeds the downstream waveform/DAC path one sample per enabled clock.

Parameters:
- WIDTH, 8, sample and LUT word width (two's complement).
- DEPTH, 256, LUT entry count (power of two); AW = $clog2(DEPTH).
- PHASE_W, 24, phase accumulator width; must be >= AW+2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance phase and capture a sample this cycle
- clr  in  1  synchronous phase clear (0) without touching tuning word
- tw_load  in  1  capture tuning_word into active tuning register
- tuning_word  in  PHASE_W  frequency control word
- rom_addr  out  AW  LUT address, combinational from phase register
- rom_data  in  WIDTH  LUT data returned combinationally for rom_addr
- sample  out  WIDTH  registered output sample
- sample_valid  out  1  high for one cycle per captured sample
- wrap  out  1  one-cycle pulse, phase accumulator carried out

Behaviour:
- Reset (rst=1 at edge): phase=0, tw_active=0, sample=0, sample_valid=0, wrap=0. rst overrides all other inputs.
- rom_addr = phase[PHASE_W-1 -: AW] (full-wave build); no register between phase and rom_addr.
- Edge with en=1: sample <= rom_data (value for the current phase), sample_valid <= 1, phase <= phase + tw_active (mod 2^PHASE_W), wrap <= carry-out of that add.
- Edge with en=0: phase and sample hold, sample_valid <= 0, wrap <= 0.
- Latency: first en cycle -> sample_valid high the following cycle, carrying LUT[addr of phase 0 after reset/clr].
- tw_load: tw_active <= tuning_word. When asserted together with en, the increment on that edge uses the old tw_active; the new word applies from the next enabled edge.
- clr: phase <= 0 regardless of en and takes priority over the increment. When clr and en coincide, the sample is still captured from the pre-clear phase and wrap <= 0.
- tw_active=0 with en: constant address, valid every cycle, wrap never asserts.
- Tuning word with MSB set is legal; it aliases to the negative frequency through normal modular wrap.

Optional Feature:
- Macro DDS_QUARTER_WAVE_EN.
- Defined: the LUT holds a quarter period (DEPTH entries, values >= 0), so a full period is 4*DEPTH steps.
  - sign = phase[PHASE_W-1], mirror = phase[PHASE_W-2], idx = phase[PHASE_W-3 -: AW].
  - rom_addr = mirror ? ~idx : idx.
  - On capture, sample <= sign ? -rom_data : rom_data. sign is taken from the same phase that drove rom_addr, so no extra delay is needed.
- Undefined: full-wave table, rom_addr as above, no negation. Latency is identical in both builds.

Decomposition:
- Package dds_pkg:
  - localparam defaults (PHASE_W_DEF=24).
  - Function addr_w(depth) wrapping $clog2.
  - typedef phase_t (logic [PHASE_W_DEF-1:0]).
- Sub-module phase_accum:
  - Owns phase, tw_active, the clr/tw_load priority and the wrap carry.
  - Top level adds address mapping and sample capture.

Test Plan (WIDTH=8, DEPTH=256, PHASE_W=16, identity LUT LUT[i]=i, full-wave unless noted):
- rst, tw_load tw=0x0100, then en held -> rom_addr 0,1,2,... each cycle; samples 0x00,0x01,...; wrap pulses exactly once per 256 enabled cycles.
- tw=0x8000, en held -> rom_addr alternates 0,128; wrap on every second enabled cycle; sample 0x00,0x80,0x00,...
- en toggled 1,0,1 with tw=0x0100 -> sample_valid 1,0,1 one cycle later; the sample holds during the gap; the phase does not advance while en=0.
- tw_load to 0x0200 on the same edge as en -> that step still +1 address; subsequent steps +2.
- clr and rst asserted mid-run at addr 0x37 -> clr: next rom_addr 0, and the sample captured that edge is 0x37. rst: all outputs 0 next cycle, tw_active 0.
- DDS_QUARTER_WAVE_EN, tw=0x0040 -> idx steps by 1; addr rises 0..255 in Q1 and falls 255..0 in Q2. Q3/Q4 produce the two's complement negatives (LUT[5]=5 yields 0xFB).

Source files
------------

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS LUT reader slice.
//   PHASE_W_DEF : default phase accumulator width
//   addr_w()    : LUT address width for a power-of-two table depth
//   phase_t     : phase word at the default accumulator width
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int PHASE_W_DEF = 24;
  localparam int WIDTH_DEF   = 8;
  localparam int DEPTH_DEF   = 256;

  typedef logic [PHASE_W_DEF-1:0] phase_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/phase_accum.sv
// -----------------------------------------------------------------------------
// phase_accum
// Phase accumulator with an active tuning register.
//   clk, rst      : clock, synchronous active-high reset
//   en_i          : advance phase by the active tuning word
//   clr_i         : force phase to 0 (wins over the increment)
//   tw_load_i     : capture tuning_word_i into the active tuning register
//   tuning_word_i : frequency control word
//   phase_o       : current phase (registered)
//   wrap_o        : registered carry-out of the last enabled add
// -----------------------------------------------------------------------------
module phase_accum #(
  parameter int PHASE_W = dds_pkg::PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               tw_load_i,
  input  logic [PHASE_W-1:0] tuning_word_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               wrap_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, tw_q};
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      // Clear wins; the carry of the discarded add is not reported.
      phase_d = '0;
    end else if (en_i) begin
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
    end
    // The add above always uses the old word, so a load coinciding
    // with en only takes effect from the next enabled edge.
    tw_d = tw_load_i ? tuning_word_i : tw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      tw_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tw_q    <= tw_d;
      wrap_q  <= wrap_d;
    end
  end

  assign phase_o = phase_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/dds_lut_reader.sv
// -----------------------------------------------------------------------------
// dds_lut_reader
// Phase-accumulator address generator and sample register in front of an
// asynchronous sine LUT ROM.
//   clk, rst     : clock, synchronous active-high reset
//   en           : advance phase and capture a sample this cycle
//   clr          : synchronous phase clear, tuning word untouched
//   tw_load      : load tuning_word into the active tuning register
//   tuning_word  : frequency control word
//   rom_addr     : LUT address, combinational from the phase register
//   rom_data     : LUT word returned combinationally for rom_addr
//   sample       : registered output sample
//   sample_valid : one-cycle strobe per captured sample
//   wrap         : one-cycle pulse on phase accumulator carry-out
// Build option: DDS_QUARTER_WAVE_EN selects a quarter-period table with
// address mirroring and sign restoration; undefined means a full-wave table.
// -----------------------------------------------------------------------------
module dds_lut_reader
  import dds_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int AW      = addr_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               tw_load,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic [AW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  output logic [WIDTH-1:0]   sample,
  output logic               sample_valid,
  output logic               wrap
);

  logic [PHASE_W-1:0] phase;
  logic [WIDTH-1:0]   capture_val;
  logic [WIDTH-1:0]   sample_q;
  logic               valid_q;
  logic               unused_phase_bits;

  phase_accum #(
    .PHASE_W(PHASE_W)
  ) u_phase_accum (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .clr_i        (clr),
    .tw_load_i    (tw_load),
    .tuning_word_i(tuning_word),
    .phase_o      (phase),
    .wrap_o       (wrap)
  );

  // Low phase bits only provide fractional resolution.
  assign unused_phase_bits = ^phase;

`ifdef DDS_QUARTER_WAVE_EN
  logic          sign;
  logic          mirror;
  logic [AW-1:0] idx;

  assign sign     = phase[PHASE_W-1];
  assign mirror   = phase[PHASE_W-2];
  assign idx      = phase[PHASE_W-3 -: AW];
  // Second and fourth quadrants walk the table backwards.
  assign rom_addr = mirror ? ~idx : idx;
  // sign comes from the same phase that drives rom_addr, so the returned
  // word and its sign line up in the same cycle.
  assign capture_val = sign ? -rom_data : rom_data;
`else
  assign rom_addr    = phase[PHASE_W-1 -: AW];
  assign capture_val = rom_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        sample_q <= capture_val;
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_dds_lut_reader.sv
module tb_dds_lut_reader;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 256;
  localparam int PHASE_W = 16;
  localparam int AW      = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               clr;
  logic               tw_load;
  logic [PHASE_W-1:0] tuning_word;
  logic [AW-1:0]      rom_addr;
  logic [WIDTH-1:0]   rom_data;
  logic [WIDTH-1:0]   sample;
  logic               sample_valid;
  logic               wrap;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [PHASE_W-1:0] phase_m;
  logic [PHASE_W-1:0] tw_m;
  logic               exp_valid;
  logic               exp_wrap;
  logic [WIDTH-1:0]   exp_sample;
  logic [WIDTH-1:0]   sb_q[$];
  int                 wrap_cnt;

  always #5 clk = ~clk;

  // Identity LUT
  assign rom_data = rom_addr;

  dds_lut_reader #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PHASE_W(PHASE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .tw_load     (tw_load),
    .tuning_word (tuning_word),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .wrap        (wrap)
  );

  function automatic logic [AW-1:0] addr_of(input logic [PHASE_W-1:0] p);
`ifdef DDS_QUARTER_WAVE_EN
    logic [AW-1:0] idx;
    idx = p[PHASE_W-3 -: AW];
    return p[PHASE_W-2] ? ~idx : idx;
`else
    return p[PHASE_W-1 -: AW];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] sample_of(input logic [PHASE_W-1:0] p);
    logic [WIDTH-1:0] v;
    v = addr_of(p);
`ifdef DDS_QUARTER_WAVE_EN
    if (p[PHASE_W-1]) v = 8'd0 - v;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check rom_addr, update model at the
  // edge, then check registered outputs against the scoreboard.
  task automatic step(input bit r, input bit e, input bit c, input bit l,
                      input logic [PHASE_W-1:0] tw);
    logic [PHASE_W:0] sum;
    @(negedge clk);
    rst = r; en = e; clr = c; tw_load = l; tuning_word = tw;
    #1;
    check("rom_addr", 32'(rom_addr), 32'(addr_of(phase_m)));
    @(posedge clk);
    if (r) begin
      phase_m = '0; tw_m = '0; sb_q.delete();
      exp_valid = 1'b0; exp_wrap = 1'b0; exp_sample = '0;
    end else begin
      if (e) sb_q.push_back(sample_of(phase_m));
      sum = {1'b0, phase_m} + {1'b0, tw_m};
      exp_wrap  = e && !c && sum[PHASE_W];
      exp_valid = e;
      if (c) phase_m = '0;
      else if (e) phase_m = sum[PHASE_W-1:0];
      if (l) tw_m = tw;
    end
    #1;
    check("sample_valid", 32'(sample_valid), 32'(exp_valid));
    check("wrap", 32'(wrap), 32'(exp_wrap));
    if (exp_valid) begin
      if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else exp_sample = sb_q.pop_front();
    end
    check("sample", 32'(sample), 32'(exp_sample));
    if (wrap === 1'b1) wrap_cnt++;
    $display("[TB] r=%0b en=%0b clr=%0b ld=%0b tw=%04h addr=%02h smp=%02h v=%0b wrap=%0b",
             r, e, c, l, tw, rom_addr, sample, sample_valid, wrap);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; tw_load = 1'b0; tuning_word = '0;
    phase_m = '0; tw_m = '0; exp_valid = 1'b0; exp_wrap = 1'b0; exp_sample = '0;
    wrap_cnt = 0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1, 0, 0, 0, 16'h0000);
    step(1, 1, 0, 1, 16'h1234);

    // tw=0x0100: address steps by one, one wrap per 256 enabled cycles
    step(0, 0, 0, 1, 16'h0100);
    wrap_cnt = 0;
    repeat (256) step(0, 1, 0, 0, 16'h0000);
    check("wrap_count_256", 32'(wrap_cnt), 32'd1);
    repeat (20) step(0, 1, 0, 0, 16'h0000);

    // tw=0x8000: address alternates 0,128; wrap every second step
    step(0, 0, 1, 1, 16'h8000);
    wrap_cnt = 0;
    repeat (8) step(0, 1, 0, 0, 16'h0000);
    check("wrap_count_half", 32'(wrap_cnt), 32'd4);

    // en toggling: valid follows en, sample and phase hold in the gap
    step(0, 0, 1, 1, 16'h0100);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 16'h0000);

    // tw_load together with en: this step uses the old word
    step(0, 1, 0, 1, 16'h0200);
    repeat (4) step(0, 1, 0, 0, 16'h0000);

    // clr at address 0x37 coinciding with en
    step(0, 0, 1, 1, 16'h0100);
    repeat (8'h37) step(0, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 0, 16'h0000);
`ifndef DDS_QUARTER_WAVE_EN
    check("clr_sample_37", 32'(sample), 32'h37);
`endif
    repeat (5) step(0, 1, 0, 0, 16'h0000);

    // rst mid-run overrides en; tw_active returns to 0 so address is frozen
    step(1, 1, 0, 0, 16'h0000);
    wrap_cnt = 0;
    repeat (6) step(0, 1, 0, 0, 16'h0000);
    check("wrap_count_tw0", 32'(wrap_cnt), 32'd0);

    // Negative frequency via MSB-set tuning word
    step(0, 0, 0, 1, 16'hFF00);
    repeat (10) step(0, 1, 0, 0, 16'h0000);

    // Slow sweep over a full accumulator period (quadrants in quarter build)
    step(0, 0, 1, 1, 16'h0040);
    wrap_cnt = 0;
    repeat (1030) step(0, 1, 0, 0, 16'h0000);
    check("wrap_count_slow", 32'(wrap_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
